// File: rtl/fetch_unit_if.sv
// fetch_unit_if -- bundles the pipeline-side and memory-side signals of the
// instruction fetch unit.
//   master : the fetch unit. It drives the instruction and status outputs and
//            the memory read strobe and address.
//   slave  : the surrounding pipeline and the instruction memory.
// Signals:
//   pc[15:0], fetch_req, flush          pipeline -> fetch unit
//   instr_out[15:0], instr_valid        fetch unit -> pipeline
//   fetch_stall, halted, fetch_err      fetch unit -> pipeline
//   mem_en, mem_addr[15:0]              fetch unit -> memory
//   mem_data[15:0], mem_data_valid      memory -> fetch unit
interface fetch_unit_if;
  logic [15:0] pc;
  logic        fetch_req;
  logic        flush;
  logic [15:0] instr_out;
  logic        instr_valid;
  logic        fetch_stall;
  logic        halted;
  logic        fetch_err;
  logic        mem_en;
  logic [15:0] mem_addr;
  logic [15:0] mem_data;
  logic        mem_data_valid;

  modport master (
    input  pc, fetch_req, flush, mem_data, mem_data_valid,
    output instr_out, instr_valid, fetch_stall, halted, fetch_err,
           mem_en, mem_addr
  );

  modport slave (
    output pc, fetch_req, flush, mem_data, mem_data_valid,
    input  instr_out, instr_valid, fetch_stall, halted, fetch_err,
           mem_en, mem_addr
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit -- instruction fetch with a one-entry instruction buffer.
// A request that hits the buffer is answered on the next edge. A request that
// misses issues a single-cycle memory read and then waits for the response.
// The outstanding fetch can be abandoned by a flush (the response is then
// drained) or by a response timeout. Fetching HLT (opcode 4'hF) parks the
// unit in HALT until reset.
// Ports:
//   clk    system clock; all state updates on the rising edge
//   rst_n  asynchronous active-low reset
//   bus    fetch_unit_if.master; see the interface file for the signal list
// Parameter:
//   TIMEOUT  number of WAIT/DRAIN cycles tolerated without a response (1..15)
module fetch_unit #(
  parameter int TIMEOUT = 15
) (
  input logic          clk,
  input logic          rst_n,
  fetch_unit_if.master bus
);

  typedef enum logic [1:0] {IDLE, WAIT, DRAIN, HALT} state_t;

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic        buf_valid_reg, buf_valid_next;
  logic [15:0] buf_addr_reg, buf_addr_next;
  logic [15:0] buf_data_reg, buf_data_next;
  logic [15:0] instr_out_reg, instr_out_next;
  logic        instr_valid_reg, instr_valid_next;
  logic        fetch_err_reg, fetch_err_next;
  logic        mem_en_reg, mem_en_next;
  logic [15:0] mem_addr_reg, mem_addr_next;
  logic        fetch_stall;

  logic        hit;
  logic [4:0]  cnt_inc;
  logic        timed_out;

  assign hit       = buf_valid_reg && (bus.pc == buf_addr_reg);
  // The counter holds the number of response-less cycles already spent. The
  // cycle whose increment would reach TIMEOUT is the last one allowed.
  assign cnt_inc   = {1'b0, cnt_reg} + 5'd1;
  assign timed_out = (cnt_inc == 5'(TIMEOUT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      buf_valid_reg   <= 1'b0;
      buf_addr_reg    <= '0;
      buf_data_reg    <= '0;
      instr_out_reg   <= '0;
      instr_valid_reg <= 1'b0;
      fetch_err_reg   <= 1'b0;
      mem_en_reg      <= 1'b0;
      mem_addr_reg    <= '0;
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      buf_valid_reg   <= buf_valid_next;
      buf_addr_reg    <= buf_addr_next;
      buf_data_reg    <= buf_data_next;
      instr_out_reg   <= instr_out_next;
      instr_valid_reg <= instr_valid_next;
      fetch_err_reg   <= fetch_err_next;
      mem_en_reg      <= mem_en_next;
      mem_addr_reg    <= mem_addr_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    cnt_next         = cnt_reg;
    buf_valid_next   = buf_valid_reg;
    buf_addr_next    = buf_addr_reg;
    buf_data_next    = buf_data_reg;
    instr_out_next   = instr_out_reg;
    fetch_err_next   = fetch_err_reg;
    mem_addr_next    = mem_addr_reg;
    // Strobes default low, so each one lasts exactly one cycle.
    instr_valid_next = 1'b0;
    mem_en_next      = 1'b0;
    fetch_stall      = 1'b0;

    case (state_reg)
      IDLE: begin
        // A flush cancels the request in this cycle. Responses are ignored.
        if (bus.fetch_req && !bus.flush) begin
          if (hit) begin
            instr_out_next   = buf_data_reg;
            instr_valid_next = 1'b1;
            if (buf_data_reg[15:12] == 4'hF) state_next = HALT;
          end else begin
            fetch_stall   = 1'b1;
            mem_en_next   = 1'b1;
            mem_addr_next = bus.pc;
            cnt_next      = '0;
            state_next    = WAIT;
          end
        end
      end

      WAIT: begin
        fetch_stall = 1'b1;
        if (bus.mem_data_valid) begin
          // The buffer is refilled even if a flush arrives with the data.
          // The flushed instruction is simply not delivered.
          buf_valid_next = 1'b1;
          buf_addr_next  = mem_addr_reg;
          buf_data_next  = bus.mem_data;
          state_next     = IDLE;
          if (!bus.flush) begin
            instr_out_next   = bus.mem_data;
            instr_valid_next = 1'b1;
            if (bus.mem_data[15:12] == 4'hF) state_next = HALT;
          end
        end else if (timed_out) begin
          // An expired response takes priority over a flush in the same cycle.
          fetch_err_next = 1'b1;
          state_next     = IDLE;
        end else begin
          cnt_next = cnt_inc[3:0];
          if (bus.flush) state_next = DRAIN;
        end
      end

      DRAIN: begin
        // Wait for the abandoned response so it cannot be taken for a later
        // fetch. The counter keeps running from the original request.
        if (bus.mem_data_valid) begin
          state_next = IDLE;
        end else if (timed_out) begin
          fetch_err_next = 1'b1;
          state_next     = IDLE;
        end else begin
          cnt_next = cnt_inc[3:0];
        end
      end

      HALT: begin
        fetch_stall = 1'b1;
      end

      default: state_next = IDLE;
    endcase
  end

  assign bus.instr_out   = instr_out_reg;
  assign bus.instr_valid = instr_valid_reg;
  assign bus.fetch_stall = fetch_stall;
  assign bus.halted      = (state_reg == HALT);
  assign bus.fetch_err   = fetch_err_reg;
  assign bus.mem_en      = mem_en_reg;
  assign bus.mem_addr    = mem_addr_reg;

endmodule
